// File: rtl/riscv_pkg.sv
// Shared types and default sizing for the decode/execute issue controller.
package riscv_pkg;
    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} issue_state_e;

    localparam int REG_IDX_W        = 5;
    localparam int DEF_NUM_REGS     = 32;
    localparam int DEF_CNT_W        = 2;
    localparam int DEF_MAX_INFLIGHT = 4;
endpackage

// File: rtl/issue_hazard_ctrl_reg_scoreboard.sv
// Per-register pending-write counters with busy/saturation lookup for the
// instruction currently sitting in decode.
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 inc_en,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 rd_sat
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REGS-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [NUM_REGS-1:0]            inc_vec, dec_vec;

    // Entry 0 never gets an inc/dec, so x0 always reads as idle.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_vec[r] = inc_en && (rd == REG_IDX_W'(r));
            dec_vec[r] = wb_valid && (wb_rd == REG_IDX_W'(r)) && (pend_q[r] != '0);
        end
    end

    always_comb begin
        pend_d = pend_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (inc_vec[r] && !dec_vec[r])
                pend_d[r] = pend_q[r] + CNT_W'(1);
            else if (dec_vec[r] && !inc_vec[r])
                pend_d[r] = pend_q[r] - CNT_W'(1);
        end
        pend_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    assign rs1_busy = (pend_q[rs1] != '0);
    assign rs2_busy = (pend_q[rs2] != '0);
    assign rd_sat   = (pend_q[rd] == CNT_MAX);

    // A writeback must always match an outstanding write.
    always_ff @(posedge clk) begin
        if (!rst && wb_valid && (wb_rd != '0))
            assert (pend_q[wb_rd] != '0);
    end
endmodule

// File: rtl/issue_hazard_ctrl.sv
// Decode->execute issue gating: RAW/saturation stalls, in-flight cap,
// branch flush and a drain handshake for fence/CSR sequencing.
module issue_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int  NUM_REGS     = DEF_NUM_REGS,
    parameter int  CNT_W        = DEF_CNT_W,
    parameter int  MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    localparam int IF_W         = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [REG_IDX_W-1:0] dec_rs1,
    input  logic [REG_IDX_W-1:0] dec_rs2,
    input  logic                 dec_rs1_used,
    input  logic                 dec_rs2_used,
    input  logic [REG_IDX_W-1:0] dec_rd,
    input  logic                 dec_rd_we,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 retire_nowr,
    input  logic                 flush,
    input  logic                 drain_req,
    output logic                 drain_done,
    output logic                 stall_raw,
    output logic [IF_W-1:0]      inflight_cnt
);
    issue_state_e    state_q, state_d;
    logic [IF_W-1:0] inflight_q, inflight_d;
    logic [IF_W:0]   cnt_sum, ret_n;
    logic            rs1_busy, rs2_busy, rd_sat;
    logic            hazard, issue_ok, issue;

    reg_scoreboard #(.NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .inc_en   (issue && dec_rd_we),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_sat   (rd_sat)
    );

    assign hazard = (dec_rs1_used && rs1_busy) || (dec_rs2_used && rs2_busy) ||
                    (dec_rd_we && rd_sat);

    always_comb begin
        ex_valid   = 1'b0;
        dec_ready  = 1'b0;
        drain_done = 1'b0;
        state_d    = state_q;
        issue_ok   = dec_valid && !hazard && !flush && (inflight_q < IF_W'(MAX_INFLIGHT));
        case (state_q)
            RUN: begin
                // Flush wins: decode drops its instruction without issuing it.
                if (flush) begin
                    dec_ready = 1'b1;
                end else if (issue_ok) begin
                    ex_valid  = 1'b1;
                    dec_ready = ex_ready;
                end
                if (drain_req) state_d = DRAIN;
            end
            DRAIN: begin
                drain_done = (inflight_q == '0);
                if (!drain_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            ex_valid   = 1'b0;
            dec_ready  = 1'b0;
            drain_done = 1'b0;
        end
    end

    assign issue     = ex_valid && ex_ready;
    assign stall_raw = dec_valid && hazard && (state_q == RUN);

    // One issue and up to two retires can land in the same cycle.
    always_comb begin
        ret_n   = (IF_W+1)'(wb_valid) + (IF_W+1)'(retire_nowr);
        cnt_sum = {1'b0, inflight_q} + (IF_W+1)'(issue);
        if (cnt_sum >= ret_n) cnt_sum = cnt_sum - ret_n;
        else                  cnt_sum = '0;
        inflight_d = cnt_sum[IF_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert ({1'b0, inflight_q} + (IF_W+1)'(issue) >= ret_n);
    end

    assign inflight_cnt = inflight_q;
endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Bench for issue_hazard_ctrl: directed scenarios plus randomized traffic,
// checked against a queue of outstanding instructions.
module tb_issue_hazard_ctrl;
    import riscv_pkg::*;

    logic       clk = 1'b0, rst = 1'b1;
    logic       dec_valid = 0, dec_ready, dec_rs1_used = 0, dec_rs2_used = 0, dec_rd_we = 0;
    logic [4:0] dec_rs1 = 0, dec_rs2 = 0, dec_rd = 0, wb_rd = 0;
    logic       ex_valid, ex_ready = 0, wb_valid = 0, retire_nowr = 0, flush = 0;
    logic       drain_req = 0, drain_done, stall_raw;
    logic [2:0] inflight_cnt;

    always #5 clk = ~clk;

    issue_hazard_ctrl dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs1_used(dec_rs1_used),
        .dec_rs2_used(dec_rs2_used), .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .retire_nowr(retire_nowr), .flush(flush), .drain_req(drain_req),
        .drain_done(drain_done), .stall_raw(stall_raw), .inflight_cnt(inflight_cnt)
    );

    int n_checks = 0, n_pass = 0;

    // Reference model: the list of issued-but-unretired instructions.
    typedef struct packed { logic [4:0] rd; logic we; } ent_t;
    ent_t q[$];
    bit   draining = 0;
    int   issued_total = 0;

    function automatic int pend_of(input logic [4:0] r);
        int c = 0;
        if (r == 0) return 0;
        foreach (q[i]) if (q[i].we && q[i].rd == r) c++;
        return c;
    endfunction

    function automatic bit m_hazard();
        return (dec_rs1_used && pend_of(dec_rs1) > 0) || (dec_rs2_used && pend_of(dec_rs2) > 0) ||
               (dec_rd_we && pend_of(dec_rd) == 3);
    endfunction

    function automatic bit m_ex_valid();
        return !rst && !draining && dec_valid && !flush && !m_hazard() && q.size() < 4;
    endfunction

    function automatic bit m_dec_ready();
        if (rst || draining) return 1'b0;
        if (flush) return 1'b1;
        return m_ex_valid() && ex_ready;
    endfunction

    task automatic tick();
        bit   iss;
        ent_t e;
        iss  = m_ex_valid() && ex_ready;
        e.rd = dec_rd;
        e.we = dec_rd_we;
        @(posedge clk);
        if (rst) begin
            q.delete();
            draining = 0;
        end else begin
            if (wb_valid)
                for (int i = 0; i < q.size(); i++)
                    if (q[i].we && q[i].rd == wb_rd) begin q.delete(i); break; end
            if (retire_nowr)
                for (int i = 0; i < q.size(); i++)
                    if (!q[i].we) begin q.delete(i); break; end
            if (iss) begin q.push_back(e); issued_total++; end
            if (!draining && drain_req) draining = 1;
            else if (draining && !drain_req) draining = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
        dec_rd = 0; dec_rd_we = 0; ex_ready = 1; wb_valid = 0; wb_rd = 0;
        retire_nowr = 0; flush = 0; drain_req = 0;
    endtask

    task automatic drive(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                         input logic [4:0] rd, input bit we);
        dec_valid = 1; dec_rs1 = rs1; dec_rs1_used = u1; dec_rs2 = rs2; dec_rs2_used = u2;
        dec_rd = rd; dec_rd_we = we;
    endtask

    task automatic retire_all();
        int guard = 0;
        idle();
        while (q.size() > 0 && guard < 20) begin
            if (q[0].we) begin wb_valid = 1; wb_rd = q[0].rd; end
            else retire_nowr = 1;
            #1;
            n_checks++;
            if (inflight_cnt !== 3'(q.size())) $display("FAIL retire_inflight got=%0d exp=%0d", inflight_cnt, q.size());
            else n_pass++;
            tick();
            wb_valid = 0; retire_nowr = 0;
            guard++;
        end
        n_checks++;
        if (q.size() != 0) $display("FAIL retire_timeout left=%0d exp=0", q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1; idle(); dec_valid = 1; flush = 1;
        @(negedge clk); #1;
        n_checks++; if (ex_valid !== 1'b0) $display("FAIL rst_ex_valid got=%b exp=0", ex_valid); else n_pass++;
        n_checks++; if (dec_ready !== 1'b0) $display("FAIL rst_dec_ready got=%b exp=0", dec_ready); else n_pass++;
        n_checks++; if (drain_done !== 1'b0) $display("FAIL rst_drain_done got=%b exp=0", drain_done); else n_pass++;
        n_checks++; if (stall_raw !== 1'b0) $display("FAIL rst_stall_raw got=%b exp=0", stall_raw); else n_pass++;
        n_checks++; if (inflight_cnt !== 3'd0) $display("FAIL rst_inflight got=%0d exp=0", inflight_cnt); else n_pass++;
        tick();
        rst = 0; idle();
    endtask

    task automatic test_independent();
        int base = issued_total;
        for (int cyc = 0; cyc < 30 && issued_total - base < 8; cyc++) begin
            idle();
            drive(0, 0, 0, 0, 5'(issued_total - base + 1), 1);
            if (cyc >= 5 && q.size() > 0) begin wb_valid = 1; wb_rd = q[0].rd; end
            #1;
            if (cyc <= 5) begin
                n_checks++;
                if (ex_valid !== (cyc < 4)) $display("FAIL indep_ex_valid c%0d got=%b exp=%b", cyc, ex_valid, cyc < 4);
                else n_pass++;
                n_checks++;
                if (inflight_cnt !== 3'((cyc < 4) ? cyc : 4)) $display("FAIL indep_inflight c%0d got=%0d", cyc, inflight_cnt);
                else n_pass++;
            end
            n_checks++;
            if (ex_valid !== m_ex_valid()) $display("FAIL indep_model c%0d got=%b exp=%b", cyc, ex_valid, m_ex_valid());
            else n_pass++;
            tick();
        end
        n_checks++;
        if (issued_total - base != 8) $display("FAIL indep_count got=%0d exp=8", issued_total - base);
        else n_pass++;
        retire_all();
    endtask

    task automatic test_raw();
        idle(); drive(0, 0, 0, 0, 5, 1); #1;
        n_checks++; if (ex_valid !== 1'b1) $display("FAIL raw_A_issue got=%b exp=1", ex_valid); else n_pass++;
        tick();
        idle(); drive(5, 1, 0, 0, 6, 1);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin wb_valid = 1; wb_rd = 5; end
            #1;
            n_checks++; if (stall_raw !== 1'b1) $display("FAIL raw_stall k%0d got=%b exp=1", k, stall_raw); else n_pass++;
            n_checks++; if (ex_valid !== 1'b0) $display("FAIL raw_blocked k%0d got=%b exp=0", k, ex_valid); else n_pass++;
            tick();
        end
        wb_valid = 0; #1;
        n_checks++; if (ex_valid !== 1'b1 || stall_raw !== 1'b0)
            $display("FAIL raw_B_issue ex_valid=%b stall=%b exp 1/0", ex_valid, stall_raw); else n_pass++;
        tick();
        retire_all();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            idle(); drive(0, 0, 0, 0, 7, 1); #1;
            n_checks++; if (ex_valid !== 1'b1) $display("FAIL sat_fill k%0d got=%b exp=1", k, ex_valid); else n_pass++;
            tick();
        end
        idle(); drive(0, 0, 0, 0, 7, 1); #1;
        n_checks++; if (ex_valid !== 1'b0 || stall_raw !== 1'b1)
            $display("FAIL sat_stall ex_valid=%b stall=%b exp 0/1", ex_valid, stall_raw); else n_pass++;
        tick();
        wb_valid = 1; wb_rd = 7; #1;
        n_checks++; if (ex_valid !== 1'b0) $display("FAIL sat_wb_cycle got=%b exp=0", ex_valid); else n_pass++;
        tick();
        wb_valid = 0; #1;
        n_checks++; if (ex_valid !== 1'b1) $display("FAIL sat_release got=%b exp=1", ex_valid); else n_pass++;
        tick();
        retire_all();
    endtask

    task automatic test_x0_same_cycle();
        idle(); drive(0, 0, 0, 0, 0, 1); #1;
        n_checks++; if (ex_valid !== 1'b1) $display("FAIL x0_write got=%b exp=1", ex_valid); else n_pass++;
        tick();
        idle(); drive(0, 1, 0, 1, 0, 0); #1;
        n_checks++; if (stall_raw !== 1'b0 || ex_valid !== 1'b1)
            $display("FAIL x0_read stall=%b ex_valid=%b exp 0/1", stall_raw, ex_valid); else n_pass++;
        tick();
        retire_all();
        idle(); drive(0, 0, 0, 0, 3, 1); #1; tick();
        idle(); drive(0, 0, 0, 0, 3, 1); wb_valid = 1; wb_rd = 3; #1;
        n_checks++; if (ex_valid !== 1'b1) $display("FAIL same_cycle_issue got=%b exp=1", ex_valid); else n_pass++;
        tick();
        idle(); drive(3, 1, 0, 0, 4, 1); #1;
        n_checks++; if (stall_raw !== 1'b1) $display("FAIL same_cycle_pend got=%b exp=1", stall_raw); else n_pass++;
        tick();
        retire_all();
    endtask

    task automatic test_flush();
        idle(); drive(0, 0, 0, 0, 9, 1); #1; tick();
        idle(); drive(0, 0, 0, 0, 10, 1); flush = 1; #1;
        n_checks++; if (ex_valid !== 1'b0) $display("FAIL flush_ex_valid got=%b exp=0", ex_valid); else n_pass++;
        n_checks++; if (dec_ready !== 1'b1) $display("FAIL flush_dec_ready got=%b exp=1", dec_ready); else n_pass++;
        tick();
        idle(); drive(10, 1, 0, 0, 0, 0); #1;
        n_checks++; if (ex_valid !== 1'b1 || inflight_cnt !== 3'd1)
            $display("FAIL flush_no_pend ex_valid=%b inflight=%0d exp 1/1", ex_valid, inflight_cnt); else n_pass++;
        tick();
        idle(); drive(9, 1, 0, 0, 0, 0); #1;
        n_checks++; if (stall_raw !== 1'b1) $display("FAIL flush_keeps_pend got=%b exp=1", stall_raw); else n_pass++;
        tick();
        retire_all();
    endtask

    task automatic test_drain();
        idle(); drive(0, 0, 0, 0, 11, 1); #1; tick();
        idle(); drive(0, 0, 0, 0, 12, 1); #1; tick();
        idle(); drain_req = 1; #1; tick();
        drive(0, 0, 0, 0, 13, 1); #1;
        n_checks++; if (ex_valid !== 1'b0 || dec_ready !== 1'b0 || drain_done !== 1'b0)
            $display("FAIL drain_block ex=%b rdy=%b done=%b exp 0/0/0", ex_valid, dec_ready, drain_done); else n_pass++;
        tick();
        wb_valid = 1; wb_rd = 11; #1;
        n_checks++; if (drain_done !== 1'b0) $display("FAIL drain_early1 got=%b exp=0", drain_done); else n_pass++;
        tick();
        wb_rd = 12; #1;
        n_checks++; if (drain_done !== 1'b0 || inflight_cnt !== 3'd1)
            $display("FAIL drain_early2 done=%b inflight=%0d exp 0/1", drain_done, inflight_cnt); else n_pass++;
        tick();
        wb_valid = 0; #1;
        n_checks++; if (drain_done !== 1'b1 || ex_valid !== 1'b0)
            $display("FAIL drain_done done=%b ex=%b exp 1/0", drain_done, ex_valid); else n_pass++;
        tick();
        drain_req = 0; #1;
        n_checks++; if (drain_done !== 1'b1 || ex_valid !== 1'b0)
            $display("FAIL drain_exit_edge done=%b ex=%b exp 1/0", drain_done, ex_valid); else n_pass++;
        tick();
        #1;
        n_checks++; if (ex_valid !== 1'b1 || drain_done !== 1'b0)
            $display("FAIL drain_resume ex=%b done=%b exp 1/0", ex_valid, drain_done); else n_pass++;
        tick();
        idle(); drain_req = 1; #1; tick();
        #1;
        n_checks++; if (drain_done !== 1'b0) $display("FAIL drain_busy got=%b exp=0", drain_done); else n_pass++;
        rst = 1; #1;
        n_checks++; if (inflight_cnt !== 3'd0 || drain_done !== 1'b0)
            $display("FAIL mid_reset inflight=%0d done=%b exp 0/0", inflight_cnt, drain_done); else n_pass++;
        tick();
        rst = 0; idle(); drive(13, 1, 0, 0, 14, 1); #1;
        n_checks++; if (ex_valid !== 1'b1 || stall_raw !== 1'b0)
            $display("FAIL post_reset_run ex=%b stall=%b exp 1/0", ex_valid, stall_raw); else n_pass++;
        tick();
        retire_all();
    endtask

    task automatic test_random();
        int widx[$], nidx[$], k;
        for (int cyc = 0; cyc < 400; cyc++) begin
            dec_valid    = ($urandom_range(0, 9) < 8);
            dec_rs1      = 5'($urandom_range(0, 7));
            dec_rs2      = 5'($urandom_range(0, 7));
            dec_rd       = 5'($urandom_range(0, 7));
            dec_rs1_used = 1'($urandom_range(0, 1));
            dec_rs2_used = 1'($urandom_range(0, 1));
            dec_rd_we    = ($urandom_range(0, 3) != 0);
            ex_ready     = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) drain_req = !drain_req;
            widx = {}; nidx = {};
            foreach (q[i]) if (q[i].we) widx.push_back(i); else nidx.push_back(i);
            wb_valid = 0; retire_nowr = 0;
            if (widx.size() > 0 && $urandom_range(0, 2) == 0) begin
                k = widx[$urandom_range(0, widx.size() - 1)];
                wb_valid = 1; wb_rd = q[k].rd;
            end
            if (nidx.size() > 0 && $urandom_range(0, 2) == 0) retire_nowr = 1;
            #1;
            n_checks++; if (ex_valid !== m_ex_valid())
                $display("FAIL rnd_ex_valid c%0d got=%b exp=%b", cyc, ex_valid, m_ex_valid()); else n_pass++;
            n_checks++; if (dec_ready !== m_dec_ready())
                $display("FAIL rnd_dec_ready c%0d got=%b exp=%b", cyc, dec_ready, m_dec_ready()); else n_pass++;
            n_checks++; if (stall_raw !== (dec_valid && m_hazard() && !draining))
                $display("FAIL rnd_stall c%0d got=%b", cyc, stall_raw); else n_pass++;
            n_checks++; if (inflight_cnt !== 3'(q.size()))
                $display("FAIL rnd_inflight c%0d got=%0d exp=%0d", cyc, inflight_cnt, q.size()); else n_pass++;
            n_checks++; if (drain_done !== (draining && q.size() == 0))
                $display("FAIL rnd_drain_done c%0d got=%b", cyc, drain_done); else n_pass++;
            tick();
        end
        retire_all();
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw();
        test_saturation();
        test_x0_same_cycle();
        test_flush();
        test_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
